// File: rtl/sc_scbc_reg_pkg.sv
// Shared types and constants for the scbc frame-timer register root.
// Latency: n/a (types, constants and pure helpers only).
// Backpressure: n/a.
package sc_scbc_reg_pkg;

    // Frame timer control states.
    typedef enum logic [1:0] {
        FT_IDLE  = 2'd0,
        FT_START = 2'd1,
        FT_RUN   = 2'd2
    } ftcState_t;

    // Highest frame number before the counter wraps to zero.
    localparam logic [15:0] FM_NUM11_MAX = 16'h07FF;
    localparam logic [15:0] FM_NUM16_MAX = 16'hFFFF;

    // Next frame number at a frame boundary.
    // The 11-bit form always clears bits 15:11, even if they were set in 16-bit mode.
    function automatic logic [15:0] ftc_next_frnum(input logic [15:0] num, input logic nmode16);
        logic [15:0] nxt;
        if (nmode16) begin
            nxt = (num == FM_NUM16_MAX) ? 16'h0000 : (num + 16'h0001);
        end else begin
            nxt = ({5'b00000, num[10:0]} == FM_NUM11_MAX) ? 16'h0000
                                                          : {5'b00000, (num[10:0] + 11'h001)};
        end
        return nxt;
    endfunction

    // Software-written frame number, masked to the active numbering width.
    function automatic logic [15:0] ftc_mask_frnum(input logic [15:0] num, input logic nmode16);
        return nmode16 ? num : {5'b00000, num[10:0]};
    endfunction

endpackage

// File: rtl/sc_scbc_frame_timer.sv
// USB host frame timer: down-counts the frame interval, advances fmNumber, raises one SOF request per frame.
// Latency: all outputs registered; first SOF_REQ two cycles after FM_ENABLE rises, then one per IVL+1 cycles.
// Backpressure: SOF_REQ held until SOF_ACK; a boundary with the request still pending pulses SOF_OVERRUN.
// Optional end-of-frame guard output enabled by defining SC_SCBC_FTC_EOF_GUARD_EN.
module sc_scbc_frame_timer
    import sc_scbc_reg_pkg::*;
#(
    parameter logic [15:0] MIN_INTERVAL = 16'h0100,
    parameter logic [15:0] EOF_GUARD    = 16'd1200
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FM_ENABLE,
    input  logic [15:0] FM_INTERVAL,
    input  logic        FM_NMODE,
    input  logic        FMN_WE,
    input  logic [15:0] FMN_WDATA,
    output logic [15:0] FM_REMAINING,
    output logic        FM_RTOGGLE,
    output logic [15:0] FM_NUMBER,
    output logic        FM_ACTIVE,
    output logic        SOF_REQ,
    output logic [10:0] SOF_FRNUM,
    input  logic        SOF_ACK,
    output logic        SOF_OVERRUN,
    output logic        FM_EOF_GUARD
);

    ftcState_t   state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] number_q, number_d;
    logic        rtoggle_q, rtoggle_d;
    logic        sof_req_q, sof_req_d;
    logic        overrun_q, overrun_d;

    logic [15:0] ivl;
    logic        start_load;
    logic        boundary;

    // Effective interval, clamped from below; only consumed on a counter load.
    assign ivl = (FM_INTERVAL < MIN_INTERVAL) ? MIN_INTERVAL : FM_INTERVAL;

    // Load events. A falling FM_ENABLE overrides both so nothing is loaded on the way out.
    assign start_load = FM_ENABLE && (state_q == FT_START);
    assign boundary   = FM_ENABLE && (state_q == FT_RUN) && (remaining_q == 16'h0000);

    // Next-state logic: disable returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (!FM_ENABLE) begin
            state_d = FT_IDLE;
        end else begin
            case (state_q)
                FT_IDLE:  state_d = FT_START;
                FT_START: state_d = FT_RUN;
                FT_RUN:   state_d = FT_RUN;
                default:  state_d = FT_IDLE;
            endcase
        end
    end

    // Counter, frame number, toggle and SOF handshake next values.
    always_comb begin
        remaining_d = 16'h0000;
        number_d    = number_q;
        rtoggle_d   = rtoggle_q;
        sof_req_d   = sof_req_q;
        overrun_d   = 1'b0;

        // Interval counter: zero outside START/RUN, reload on start or boundary, else count down.
        if (start_load || boundary) begin
            remaining_d = ivl;
        end else if (FM_ENABLE && (state_q == FT_RUN)) begin
            remaining_d = remaining_q - 16'h0001;
        end

        // Software write wins over a same-cycle boundary, suppressing its increment.
        // Otherwise an 11-bit mode switch clears the upper bits on the next cycle.
        if (FMN_WE) begin
            number_d = ftc_mask_frnum(FMN_WDATA, FM_NMODE);
        end else if (boundary) begin
            number_d = ftc_next_frnum(number_q, FM_NMODE);
        end else begin
            number_d = ftc_mask_frnum(number_q, FM_NMODE);
        end

        if (boundary) begin
            rtoggle_d = ~rtoggle_q;
        end

        // Request: raise on start or boundary (even if acked that cycle), drop after ack,
        // abandon on disable. An unacked request at a boundary is overwritten and flagged.
        if (!FM_ENABLE) begin
            sof_req_d = 1'b0;
        end else if (start_load || boundary) begin
            sof_req_d = 1'b1;
        end else if (sof_req_q && SOF_ACK) begin
            sof_req_d = 1'b0;
        end

        overrun_d = boundary && sof_req_q && !SOF_ACK;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= FT_IDLE;
            remaining_q <= 16'h0000;
            number_q    <= 16'h0000;
            rtoggle_q   <= 1'b0;
            sof_req_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            number_q    <= number_d;
            rtoggle_q   <= rtoggle_d;
            sof_req_q   <= sof_req_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SC_SCBC_FTC_EOF_GUARD_EN
    logic eof_guard_q, eof_guard_d;

    // Guard is computed from next-cycle values so it lines up with FM_REMAINING.
    always_comb begin
        eof_guard_d = (state_d == FT_RUN) && (remaining_d < EOF_GUARD);
    end

    // End-of-frame guard register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            eof_guard_q <= 1'b0;
        end else begin
            eof_guard_q <= eof_guard_d;
        end
    end
`else
    logic eof_guard_q;
    logic unused_eof_guard;

    // Feature disabled: no comparator, output tied low.
    assign eof_guard_q      = 1'b0;
    assign unused_eof_guard = ^EOF_GUARD;
`endif

    // Output decode from registered state.
    always_comb begin
        FM_REMAINING = remaining_q;
        FM_RTOGGLE   = rtoggle_q;
        FM_NUMBER    = number_q;
        FM_ACTIVE    = (state_q == FT_RUN);
        SOF_REQ      = sof_req_q;
        SOF_FRNUM    = number_q[10:0];
        SOF_OVERRUN  = overrun_q;
        FM_EOF_GUARD = eof_guard_q;
    end

endmodule

// File: tb/tb_sc_scbc_frame_timer.sv
// Directed bench for the frame timer: reset, timing, clamp, wrap, overrun, write/boundary, disable, guard.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Pending SOF requests are acked explicitly by the scenario tasks.
module tb_sc_scbc_frame_timer;

    logic        clk = 1'b0;
    logic        RESET;
    logic        FM_ENABLE;
    logic [15:0] FM_INTERVAL;
    logic        FM_NMODE;
    logic        FMN_WE;
    logic [15:0] FMN_WDATA;
    logic [15:0] FM_REMAINING;
    logic        FM_RTOGGLE;
    logic [15:0] FM_NUMBER;
    logic        FM_ACTIVE;
    logic        SOF_REQ;
    logic [10:0] SOF_FRNUM;
    logic        SOF_ACK;
    logic        SOF_OVERRUN;
    logic        FM_EOF_GUARD;

    int total = 0;
    int bad   = 0;

    sc_scbc_frame_timer dut (
        .CLK          (clk),
        .RESET        (RESET),
        .FM_ENABLE    (FM_ENABLE),
        .FM_INTERVAL  (FM_INTERVAL),
        .FM_NMODE     (FM_NMODE),
        .FMN_WE       (FMN_WE),
        .FMN_WDATA    (FMN_WDATA),
        .FM_REMAINING (FM_REMAINING),
        .FM_RTOGGLE   (FM_RTOGGLE),
        .FM_NUMBER    (FM_NUMBER),
        .FM_ACTIVE    (FM_ACTIVE),
        .SOF_REQ      (SOF_REQ),
        .SOF_FRNUM    (SOF_FRNUM),
        .SOF_ACK      (SOF_ACK),
        .SOF_OVERRUN  (SOF_OVERRUN),
        .FM_EOF_GUARD (FM_EOF_GUARD)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        SOF_ACK = 1'b1;
        tick();
        SOF_ACK = 1'b0;
    endtask

    task automatic write_num(input logic [15:0] d);
        FMN_WE    = 1'b1;
        FMN_WDATA = d;
        tick();
        FMN_WE    = 1'b0;
    endtask

    // Disable for a cycle, then enable: returns in the first RUN cycle.
    task automatic start_run();
        FM_ENABLE = 1'b0;
        tick();
        FM_ENABLE = 1'b1;
        tick();
        tick();
    endtask

    // Ticks until FM_RTOGGLE flips; n = ticks taken.
    task automatic wait_boundary(output int n);
        logic t0;
        t0 = FM_RTOGGLE;
        n  = 0;
        while (FM_RTOGGLE === t0 && n < 2000) begin
            tick();
            n++;
        end
        if (FM_RTOGGLE === t0) begin
            total++;
            bad++;
            $display("FAIL wait_boundary timeout after %0d cycles", n);
        end
    endtask

    task automatic wait_remaining(input logic [15:0] v);
        int n;
        n = 0;
        while (FM_REMAINING !== v && n < 2000) begin
            tick();
            n++;
        end
        if (FM_REMAINING !== v) begin
            total++;
            bad++;
            $display("FAIL wait_remaining timeout got=%h want=%h", FM_REMAINING, v);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; FM_ENABLE = 1'b0; FM_INTERVAL = 16'hEA5F; FM_NMODE = 1'b0;
        FMN_WE = 1'b0; FMN_WDATA = 16'h0000; SOF_ACK = 1'b0;
        tick(); tick(); tick();
        total++; if (FM_REMAINING !== 16'h0000) begin bad++; $display("FAIL rst_remaining got=%h exp=0000", FM_REMAINING); end
        total++; if (FM_NUMBER !== 16'h0000) begin bad++; $display("FAIL rst_number got=%h exp=0000", FM_NUMBER); end
        total++; if ({FM_RTOGGLE, FM_ACTIVE, SOF_REQ, SOF_OVERRUN, FM_EOF_GUARD} !== 5'b00000) begin
            bad++; $display("FAIL rst_flags got=%b exp=00000", {FM_RTOGGLE, FM_ACTIVE, SOF_REQ, SOF_OVERRUN, FM_EOF_GUARD}); end
        total++; if (SOF_FRNUM !== 11'h000) begin bad++; $display("FAIL rst_frnum got=%h exp=000", SOF_FRNUM); end
    endtask

    task automatic test_first_frame();
        int n;
        RESET = 1'b0; FM_INTERVAL = 16'h0200; FM_ENABLE = 1'b1;
        tick();
        total++; if ({FM_ACTIVE, SOF_REQ} !== 2'b00) begin bad++; $display("FAIL t1_start got=%b exp=00", {FM_ACTIVE, SOF_REQ}); end
        tick();
        total++; if ({FM_ACTIVE, SOF_REQ} !== 2'b11) begin bad++; $display("FAIL t1_run_req got=%b exp=11", {FM_ACTIVE, SOF_REQ}); end
        total++; if (SOF_FRNUM !== 11'h000) begin bad++; $display("FAIL t1_frnum0 got=%h exp=000", SOF_FRNUM); end
        total++; if (FM_REMAINING !== 16'h0200) begin bad++; $display("FAIL t1_load got=%h exp=0200", FM_REMAINING); end
        do_ack();
        total++; if (SOF_REQ !== 1'b0) begin bad++; $display("FAIL t1_ack_drop got=%b exp=0", SOF_REQ); end
        total++; if (FM_REMAINING !== 16'h01FF) begin bad++; $display("FAIL t1_dec got=%h exp=01FF", FM_REMAINING); end
        wait_boundary(n);
        total++; if (n + 1 !== 513) begin bad++; $display("FAIL t1_period got=%0d exp=513", n + 1); end
        total++; if ({SOF_REQ, FM_RTOGGLE} !== 2'b11) begin bad++; $display("FAIL t1_req_tog got=%b exp=11", {SOF_REQ, FM_RTOGGLE}); end
        total++; if (SOF_FRNUM !== 11'h001) begin bad++; $display("FAIL t1_frnum1 got=%h exp=001", SOF_FRNUM); end
        do_ack();
    endtask

    task automatic test_clamp();
        int n;
        FM_INTERVAL = 16'h0010;
        start_run();
        total++; if (FM_REMAINING !== 16'h0100) begin bad++; $display("FAIL t2_clamp got=%h exp=0100", FM_REMAINING); end
        do_ack();
        FM_INTERVAL = 16'h0300;
        wait_boundary(n);
        total++; if (n + 1 !== 257) begin bad++; $display("FAIL t2_period got=%0d exp=257", n + 1); end
        total++; if (FM_REMAINING !== 16'h0300) begin bad++; $display("FAIL t2_newivl got=%h exp=0300", FM_REMAINING); end
        total++; if (FM_NUMBER !== 16'h0002) begin bad++; $display("FAIL t2_number got=%h exp=0002", FM_NUMBER); end
        FM_INTERVAL = 16'h0100;
    endtask

    task automatic test_wrap();
        int n;
        start_run();
        do_ack();
        FM_NMODE = 1'b0;
        write_num(16'h07FF);
        total++; if (FM_NUMBER !== 16'h07FF) begin bad++; $display("FAIL t3_wr7ff got=%h exp=07FF", FM_NUMBER); end
        wait_boundary(n);
        total++; if (FM_NUMBER !== 16'h0000) begin bad++; $display("FAIL t3_wrap11 got=%h exp=0000", FM_NUMBER); end
        do_ack();
        FM_NMODE = 1'b1;
        write_num(16'hFFFF);
        total++; if (FM_NUMBER !== 16'hFFFF) begin bad++; $display("FAIL t3_wrffff got=%h exp=FFFF", FM_NUMBER); end
        wait_boundary(n);
        total++; if (FM_NUMBER !== 16'h0000) begin bad++; $display("FAIL t3_wrap16 got=%h exp=0000", FM_NUMBER); end
        do_ack();
        write_num(16'hF123);
        total++; if (FM_NUMBER !== 16'hF123) begin bad++; $display("FAIL t3_wr16 got=%h exp=F123", FM_NUMBER); end
        FM_NMODE = 1'b0;
        tick();
        total++; if (FM_NUMBER !== 16'h0123) begin bad++; $display("FAIL t3_modeclr got=%h exp=0123", FM_NUMBER); end
        write_num(16'hF456);
        total++; if (FM_NUMBER !== 16'h0456) begin bad++; $display("FAIL t3_wr11 got=%h exp=0456", FM_NUMBER); end
    endtask

    task automatic test_overrun();
        int n;
        FM_NMODE = 1'b1;
        write_num(16'h0100);
        wait_boundary(n);
        total++; if ({SOF_REQ, SOF_OVERRUN} !== 2'b10) begin bad++; $display("FAIL t4_clean got=%b exp=10", {SOF_REQ, SOF_OVERRUN}); end
        wait_boundary(n);
        total++; if ({SOF_REQ, SOF_OVERRUN} !== 2'b11) begin bad++; $display("FAIL t4_ovr got=%b exp=11", {SOF_REQ, SOF_OVERRUN}); end
        total++; if (SOF_FRNUM !== 11'h102) begin bad++; $display("FAIL t4_ovr_frnum got=%h exp=102", SOF_FRNUM); end
        tick();
        total++; if ({SOF_REQ, SOF_OVERRUN} !== 2'b10) begin bad++; $display("FAIL t4_ovr_pulse got=%b exp=10", {SOF_REQ, SOF_OVERRUN}); end
        wait_remaining(16'h0000);
        SOF_ACK = 1'b1;
        tick();
        SOF_ACK = 1'b0;
        total++; if ({SOF_REQ, SOF_OVERRUN} !== 2'b10) begin bad++; $display("FAIL t4_ackb got=%b exp=10", {SOF_REQ, SOF_OVERRUN}); end
        total++; if (FM_NUMBER !== 16'h0103) begin bad++; $display("FAIL t4_ackb_num got=%h exp=0103", FM_NUMBER); end
        tick();
        total++; if ({SOF_REQ, SOF_OVERRUN} !== 2'b10) begin bad++; $display("FAIL t4_ackb_hold got=%b exp=10", {SOF_REQ, SOF_OVERRUN}); end
        do_ack();
    endtask

    task automatic test_write_boundary_disable();
        logic t0;
        wait_remaining(16'h0000);
        t0 = FM_RTOGGLE;
        write_num(16'h0055);
        total++; if (FM_NUMBER !== 16'h0055) begin bad++; $display("FAIL t5_wrb_num got=%h exp=0055", FM_NUMBER); end
        total++; if (SOF_FRNUM !== 11'h055) begin bad++; $display("FAIL t5_wrb_frnum got=%h exp=055", SOF_FRNUM); end
        total++; if ({SOF_REQ, FM_RTOGGLE} !== {1'b1, ~t0}) begin bad++; $display("FAIL t5_wrb_req_tog got=%b exp=%b", {SOF_REQ, FM_RTOGGLE}, {1'b1, ~t0}); end
        tick(); tick(); tick();
        FM_ENABLE = 1'b0;
        tick();
        total++; if (FM_REMAINING !== 16'h0000) begin bad++; $display("FAIL t5_dis_rem got=%h exp=0000", FM_REMAINING); end
        total++; if ({SOF_REQ, FM_ACTIVE} !== 2'b00) begin bad++; $display("FAIL t5_dis_req got=%b exp=00", {SOF_REQ, FM_ACTIVE}); end
        total++; if ({FM_NUMBER, FM_RTOGGLE} !== {16'h0055, ~t0}) begin bad++; $display("FAIL t5_dis_hold got=%h exp=%h", {FM_NUMBER, FM_RTOGGLE}, {16'h0055, ~t0}); end
    endtask

    task automatic test_eof_guard();
        int n;
        logic exp_g;
`ifdef SC_SCBC_FTC_EOF_GUARD_EN
        exp_g = 1'b1;
`else
        exp_g = 1'b0;
`endif
        FM_INTERVAL = 16'h04C0;
        start_run();
        total++; if (FM_EOF_GUARD !== 1'b0) begin bad++; $display("FAIL t6_load got=%b exp=0", FM_EOF_GUARD); end
        do_ack();
        wait_remaining(16'd1200);
        total++; if (FM_EOF_GUARD !== 1'b0) begin bad++; $display("FAIL t6_at1200 got=%b exp=0", FM_EOF_GUARD); end
        tick();
        total++; if (FM_EOF_GUARD !== exp_g) begin bad++; $display("FAIL t6_below got=%b exp=%b", FM_EOF_GUARD, exp_g); end
        wait_remaining(16'h0000);
        total++; if (FM_EOF_GUARD !== exp_g) begin bad++; $display("FAIL t6_zero got=%b exp=%b", FM_EOF_GUARD, exp_g); end
        wait_boundary(n);
        total++; if ({FM_REMAINING, FM_EOF_GUARD} !== {16'h04C0, 1'b0}) begin bad++; $display("FAIL t6_reload got=%h exp=%h", {FM_REMAINING, FM_EOF_GUARD}, {16'h04C0, 1'b0}); end
        do_ack();
    endtask

    task automatic test_reset_midframe();
        tick(); tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        total++; if ({FM_REMAINING, FM_NUMBER} !== 32'h0) begin bad++; $display("FAIL t7_rst_vals got=%h exp=00000000", {FM_REMAINING, FM_NUMBER}); end
        total++; if ({FM_RTOGGLE, FM_ACTIVE, SOF_REQ, SOF_OVERRUN, FM_EOF_GUARD} !== 5'b00000) begin
            bad++; $display("FAIL t7_rst_flags got=%b exp=00000", {FM_RTOGGLE, FM_ACTIVE, SOF_REQ, SOF_OVERRUN, FM_EOF_GUARD}); end
        FM_ENABLE = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_clamp();
        test_wrap();
        test_overrun();
        test_write_boundary_disable();
        test_eof_guard();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
